// File: rtl/sm_regview_pkg.sv
// Shared encodings and sizing helper for the register-view controller.
package sm_regview_pkg;

  // Display mode encoding (autoMode output carries this bit directly).
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Sample FSM encoding.
  localparam logic ST_SETTLE = 1'b0;
  localparam logic ST_TRACK  = 1'b1;

  // Counter width for a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_debounce.sv
// Key debouncer: two-flop synchronizer, stability counter and a one-cycle
// pulse on every accepted released->pressed transition of an active-low key.
module sm_debounce
  import sm_regview_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Bring the raw key into the clock domain; reset parks it at "released".
  // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= in_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  // NOTE: press gets a default first so it drops back to 0 every cycle it is not re-asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sm_regview_ctrl.sv
// Debug-view controller: picks the register index shown on the hex display,
// steps it by keys or an auto-scan timer, and latches regData once settled.
module sm_regview_ctrl
  import sm_regview_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_PERIOD     = 50000000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_next_n,
  input  logic        key_prev_n,
  input  logic        key_mode_n,
  input  logic [31:0] regData,
  output logic [4:0]  regAddr,
  output logic [31:0] number,
  output logic        autoMode,
  output logic        dataValid
);

  localparam int SCAN_W   = cnt_width(SCAN_PERIOD);
  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);

  logic                next_press;
  logic                prev_press;
  logic                mode_press;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [4:0]          addr_d;
  logic                addr_chg;
  logic                state;
  logic [SETTLE_W-1:0] settle_cnt;

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst   (rst),
    .in_n  (key_next_n),
    .press (next_press)
  );

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .rst   (rst),
    .in_n  (key_prev_n),
    .press (prev_press)
  );

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .in_n  (key_mode_n),
    .press (mode_press)
  );

  // Mode toggling, auto-scan timer and address stepping (mode key wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      regAddr  <= 5'h0;
      autoMode <= MODE_MANUAL;
      scan_cnt <= '0;
    end else if (mode_press) begin
      autoMode <= ~autoMode;
      scan_cnt <= '0;
    end else if (autoMode == MODE_AUTO) begin
      if (scan_cnt == SCAN_W'(SCAN_PERIOD - 1)) begin
        scan_cnt <= '0;
        regAddr  <= regAddr + 5'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end else if (next_press && !prev_press) begin
      regAddr <= regAddr + 5'd1;
    end else if (prev_press && !next_press) begin
      regAddr <= regAddr - 5'd1;
    end
  end

  // The address shown changed since last cycle; regData is not trustworthy yet.
  assign addr_chg = (regAddr != addr_d);

  // Sample FSM: wait for regData to settle after an address change, then track it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_d     <= 5'h0;
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      number     <= 32'h0;
    end else begin
      addr_d <= regAddr;
      if (addr_chg) begin
        state      <= ST_SETTLE;
        settle_cnt <= '0;
      end else if (state == ST_SETTLE) begin
        if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state      <= ST_TRACK;
          settle_cnt <= '0;
          number     <= regData;
        end else begin
          settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
      end else begin
        number <= regData;
      end
    end
  end

  // Valid only while tracking and before a fresh address change is acted on.
  assign dataValid = (state == ST_TRACK) && !addr_chg;

endmodule

// File: tb/tb_sm_regview_ctrl.sv
// Self-checking bench for sm_regview_ctrl: directed scenarios plus random key
// activity, compared every cycle against a behavioural model.
module tb_sm_regview_ctrl;

  localparam int DEB    = 4;
  localparam int SCAN   = 10;
  localparam int SETTLE = 2;
  localparam int MAXC   = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_next_n;
  logic        key_prev_n;
  logic        key_mode_n;
  logic [31:0] regData;
  logic [4:0]  regAddr;
  logic [31:0] number;
  logic        autoMode;
  logic        dataValid;

  int checks = 0;
  int errors = 0;

  sm_regview_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SCAN_PERIOD     (SCAN),
    .SETTLE_CYCLES   (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .key_mode_n (key_mode_n),
    .regData    (regData),
    .regAddr    (regAddr),
    .number     (number),
    .autoMode   (autoMode),
    .dataValid  (dataValid)
  );

  always #5 clk = ~clk;

  // Reference model state. Keys are indexed 0=next, 1=prev, 2=mode.
  int          cyc = 0;
  logic [2:0]  hist [0:MAXC-1];
  logic [2:0]  deb;
  logic [2:0]  m_press;
  int          run [3];
  logic [4:0]  m_addr;
  logic [31:0] m_num;
  logic        m_auto;
  int          auto_cyc;
  int          last_change;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  // A key level counts as accepted once the synchronized (two edges late) raw
  // level has disagreed with the accepted level for DEB consecutive edges.
  task automatic model_edge();
    logic [4:0] old;
    logic       synced;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "model history exhausted");
    end
    hist[cyc] = {key_mode_n, key_prev_n, key_next_n};
    if (rst) begin
      m_addr      = 5'h0;
      m_num       = 32'h0;
      m_auto      = 1'b0;
      auto_cyc    = 0;
      last_change = cyc - 1;
      hist[cyc]   = 3'b111;
      hist[cyc-1] = 3'b111;
      deb         = 3'b111;
      m_press     = 3'b000;
      run         = '{0, 0, 0};
      return;
    end
    old = m_addr;
    if (m_press[2]) begin
      m_auto   = ~m_auto;
      auto_cyc = 0;
    end else if (m_auto) begin
      auto_cyc++;
      if (auto_cyc % SCAN == 0) m_addr = m_addr + 5'd1;
    end else if (m_press[0] != m_press[1]) begin
      m_addr = m_press[0] ? m_addr + 5'd1 : m_addr - 5'd1;
    end
    if (cyc - last_change > SETTLE) m_num = regData;
    if (m_addr != old) last_change = cyc;
    for (int i = 0; i < 3; i++) begin
      synced     = (cyc >= 2) ? hist[cyc-2][i] : 1'b1;
      m_press[i] = 1'b0;
      if (synced != deb[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          deb[i]     = synced;
          run[i]     = 0;
          m_press[i] = ~synced;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("addr",  32'(regAddr),   32'(m_addr));
    check("num",   number,         m_num);
    check("auto",  32'(autoMode),  32'(m_auto));
    check("valid", 32'(dataValid), 32'(cyc - last_change > SETTLE));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive {mode, prev, next} raw levels for n cycles.
  task automatic keys(input logic [2:0] lvl, input int n);
    {key_mode_n, key_prev_n, key_next_n} = lvl;
    run_cycles(n);
  endtask

  // A clean press: held long enough to debounce, then released long enough too.
  task automatic press(input logic [2:0] lvl);
    keys(lvl, 8);
    keys(3'b111, 8);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run_cycles(n);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    key_mode_n = 1'b1;
    regData    = 32'h1234_5678;

    // 1: long hold of next gives exactly one step; number follows regData.
    do_reset(3);
    check("s1_reset_addr", 32'(regAddr), 32'h0);
    check("s1_reset_valid", 32'(dataValid), 32'h0);
    keys(3'b110, 20);
    keys(3'b111, 10);
    check("s1_addr", 32'(regAddr), 32'h1);
    check("s1_number", number, 32'h1234_5678);
    check("s1_valid", 32'(dataValid), 32'h1);

    // 2: a 3-cycle glitch is rejected; prev steps 0 -> 31 -> 30 -> 29.
    do_reset(2);
    keys(3'b110, 3);
    keys(3'b111, 10);
    check("s2_glitch", 32'(regAddr), 32'h0);
    press(3'b101);
    check("s2_prev1", 32'(regAddr), 32'd31);
    press(3'b101);
    check("s2_prev2", 32'(regAddr), 32'd30);
    press(3'b101);
    check("s2_prev3", 32'(regAddr), 32'd29);

    // 3: 31 wraps forward to 0; simultaneous next+prev leaves the address.
    do_reset(2);
    press(3'b101);
    check("s3_at31", 32'(regAddr), 32'd31);
    press(3'b110);
    check("s3_wrap", 32'(regAddr), 32'd0);
    press(3'b100);
    check("s3_both", 32'(regAddr), 32'd0);

    // 4: auto scan steps every SCAN cycles, ignores next, stops on second mode press.
    do_reset(2);
    press(3'b011);
    check("s4_auto_on", 32'(autoMode), 32'h1);
    run_cycles(1);
    check("s4_step1", 32'(regAddr), 32'd1);
    press(3'b110);
    check("s4_step2", 32'(regAddr), 32'd2);
    press(3'b011);
    check("s4_auto_off", 32'(autoMode), 32'h0);
    check("s4_last", 32'(regAddr), 32'd3);
    run_cycles(20);
    check("s4_stopped", 32'(regAddr), 32'd3);

    // 5: tracking follows regData; back-to-back changes extend the settle window.
    do_reset(2);
    run_cycles(10);
    regData = 32'hDEAD_BEEF;
    run_cycles(1);
    regData = 32'h0000_0042;
    run_cycles(1);
    check("s5_track", number, 32'h0000_0042);
    check("s5_valid", 32'(dataValid), 32'h1);
    keys(3'b110, 1);
    keys(3'b100, 7);
    keys(3'b101, 1);
    keys(3'b111, 8);
    check("s5_addr", 32'(regAddr), 32'd0);

    // 6: reset during an auto scan with prev held, then prev fires once.
    do_reset(2);
    press(3'b011);
    run_cycles(7);
    keys(3'b101, 2);
    do_reset(1);
    check("s6_rst_addr", 32'(regAddr), 32'h0);
    check("s6_rst_num", number, 32'h0);
    check("s6_rst_auto", 32'(autoMode), 32'h0);
    check("s6_rst_valid", 32'(dataValid), 32'h0);
    keys(3'b101, 12);
    keys(3'b111, 8);
    check("s6_prev", 32'(regAddr), 32'd31);

    // Random phase: key toggles of varied duration, data churn, rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) key_next_n = ~key_next_n;
      if ($urandom_range(7) == 0) key_prev_n = ~key_prev_n;
      if ($urandom_range(9) == 0) key_mode_n = ~key_mode_n;
      if ($urandom_range(2) == 0) regData = $urandom;
      rst = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
